mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 131 +++++++++++++
 tb/tb_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Processor-facing memory responder: word RAM, MMIO cycle counter, and a TX FIFO
// drained through a valid/ready port. Reads are combinational; all state is clocked.
module mem_responder #(
    parameter int unsigned MEM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] SEL_CYCLE  = 2'd0;
    localparam logic [1:0] SEL_TXDATA = 2'd1;
    localparam logic [1:0] SEL_STATUS = 2'd2;

    logic [31:0]   ram      [MEM_WORDS];
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic [31:0]   cycle;

    logic          is_mmio;
    logic [1:0]    sel;
    logic [AW-1:0] ram_idx;
    logic          wr_ram;
    logic          wr_cycle;
    logic          wr_tx;
    logic          wr_status;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic [31:0]   status;
    logic          unused_adr;

    // Address decode; upper RAM address bits and byte offset are don't-care
    assign is_mmio   = Adr[31];
    assign sel       = Adr[3:2];
    assign ram_idx   = Adr[AW+1:2];
    assign unused_adr = ^{Adr[30:AW+2], Adr[1:0]};

    assign wr_ram    = MemWrite & ~is_mmio;
    assign wr_cycle  = MemWrite & is_mmio & (sel == SEL_CYCLE);
    assign wr_tx     = MemWrite & is_mmio & (sel == SEL_TXDATA);
    assign wr_status = MemWrite & is_mmio & (sel == SEL_STATUS);

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = ~empty & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push  = wr_tx & (~full | pop);

    assign status    = {24'd0, 4'(count), 1'b0, ovf, empty, full};
    assign out_valid = ~empty;
    assign out_data  = empty ? 32'd0 : fifo_mem[rd_ptr];

    always_comb begin
        ReadData = 32'd0;
        if (!is_mmio) begin
            ReadData = ram[ram_idx];
        end else begin
            case (sel)
                SEL_CYCLE:  ReadData = cycle;
                SEL_STATUS: ReadData = status;
                default:    ReadData = 32'd0;
            endcase
        end
    end

    // RAM and FIFO storage are not reset; only occupancy/pointers are
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle <= 32'd0;
        end else if (wr_cycle) begin
            cycle <= 32'd0;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_tx && !push) begin
                ovf <= 1'b1;
            end else if (wr_status) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized traffic, all checked
// against a queue/array reference model of the RAM, counter and TX FIFO.
module tb_mem_responder;

    localparam logic [31:0] A_CYC = 32'h8000_0000;
    localparam logic [31:0] A_TX  = 32'h8000_0004;
    localparam logic [31:0] A_ST  = 32'h8000_0008;
    localparam logic [31:0] A_RSV = 32'h8000_000C;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_ram [64];
    bit          m_ram_ok [64];
    logic [31:0] m_cycle;
    logic [31:0] m_q [$];
    bit          m_ovf;

    logic [31:0] rd;
    logic        ov;
    logic [31:0] od;

    mem_responder #(.MEM_WORDS(64), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Adr       (Adr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        int c = m_q.size();
        return {24'd0, 4'(c), 1'b0, m_ovf, c == 0, c == DEPTH};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cycle = 32'd0;
        m_ovf   = 1'b0;
    endtask

    // One bus cycle: drive at negedge, check just after, advance model at posedge
    task automatic step(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic rdy, output logic [31:0] r, output logic v,
                        output logic [31:0] d);
        logic [31:0] exp_rd;
        bit          known;
        bit          popped;
        @(negedge clk);
        MemWrite  = we;
        Adr       = adr;
        WriteData = wd;
        out_ready = rdy;
        #1;
        r = ReadData;
        v = out_valid;
        d = out_data;
        known  = 1'b1;
        exp_rd = 32'd0;
        if (!adr[31]) begin
            known  = m_ram_ok[adr[7:2]];
            exp_rd = m_ram[adr[7:2]];
        end else if (adr[3:2] == 2'd0) begin
            exp_rd = m_cycle;
        end else if (adr[3:2] == 2'd2) begin
            exp_rd = model_status();
        end
        if (known) chk("readdata", r, exp_rd);
        chk("out_valid", 32'(v), 32'(m_q.size() != 0));
        chk("out_data", d, (m_q.size() != 0) ? m_q[0] : 32'd0);
        @(posedge clk);
        popped  = (m_q.size() != 0) && rdy;
        m_cycle = (we && adr[31] && adr[3:2] == 2'd0) ? 32'd0 : m_cycle + 32'd1;
        if (we && !adr[31]) begin
            m_ram[adr[7:2]]    = wd;
            m_ram_ok[adr[7:2]] = 1'b1;
        end
        if (we && adr[31] && adr[3:2] == 2'd2) m_ovf = 1'b0;
        if (popped) void'(m_q.pop_front());
        if (we && adr[31] && adr[3:2] == 2'd1) begin
            if (m_q.size() < DEPTH) m_q.push_back(wd);
            else m_ovf = 1'b1;
        end
    endtask

    initial begin
        logic        we;
        logic [31:0] adr;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        Adr       = A_ST;
        WriteData = 32'd0;
        out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_status", ReadData, 32'h2);
        @(posedge clk);
        #2 reset = 1'b1;

        // Counter: 0 right after release, 10 after ten edges, cleared by write
        step(0, A_CYC, 0, 0, rd, ov, od);
        chk("cycle_first", rd, 32'd0);
        repeat (9) step(0, A_CYC, 0, 0, rd, ov, od);
        step(0, A_CYC, 0, 0, rd, ov, od);
        chk("cycle_10", rd, 32'd10);
        step(1, A_CYC, 32'h1234_5678, 0, rd, ov, od);
        step(0, A_CYC, 0, 0, rd, ov, od);
        chk("cycle_clear", rd, 32'd0);

        // RAM and reserved window
        step(1, 32'h14, 32'h1234_5678, 0, rd, ov, od);
        step(1, 32'h10, 32'hDEAD_BEEF, 0, rd, ov, od);
        step(0, 32'h10, 0, 0, rd, ov, od);
        chk("ram_10", rd, 32'hDEAD_BEEF);
        step(0, 32'h13, 0, 0, rd, ov, od);
        chk("ram_13", rd, 32'hDEAD_BEEF);
        step(0, 32'h14, 0, 0, rd, ov, od);
        chk("ram_14", rd, 32'h1234_5678);
        step(1, A_RSV, 32'hFFFF_FFFF, 0, rd, ov, od);
        step(0, A_RSV, 0, 0, rd, ov, od);
        chk("reserved", rd, 32'd0);
        step(0, A_TX, 0, 0, rd, ov, od);
        chk("txdata_read", rd, 32'd0);

        // Fill past full, clear ovf, then drain in order
        for (int i = 1; i <= 5; i++) step(1, A_TX, 32'(i), 0, rd, ov, od);
        step(0, A_ST, 0, 0, rd, ov, od);
        chk("fill_status", rd, 32'h45);
        step(1, A_ST, 0, 0, rd, ov, od);
        step(0, A_ST, 0, 0, rd, ov, od);
        chk("ovf_clear", rd, 32'h41);
        for (int i = 1; i <= 4; i++) begin
            step(0, A_ST, 0, 1, rd, ov, od);
            chk("drain_valid", 32'(ov), 32'd1);
            chk("drain_data", od, 32'(i));
        end
        step(0, A_ST, 0, 1, rd, ov, od);
        chk("drained_valid", 32'(ov), 32'd0);
        chk("drained_status", rd, 32'h2);

        // Push into a full FIFO while popping
        for (int i = 5; i <= 8; i++) step(1, A_TX, 32'(i), 0, rd, ov, od);
        step(1, A_TX, 32'd9, 1, rd, ov, od);
        step(0, A_ST, 0, 0, rd, ov, od);
        chk("pushpop_status", rd, 32'h41);
        for (int i = 6; i <= 9; i++) begin
            step(0, A_ST, 0, 1, rd, ov, od);
            chk("pushpop_data", od, 32'(i));
        end

        // Asynchronous reset with entries queued
        for (int i = 1; i <= 3; i++) step(1, A_TX, 32'(i + 20), 0, rd, ov, od);
        @(negedge clk);
        MemWrite  = 1'b0;
        Adr       = A_ST;
        out_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data", out_data, 32'd0);
        chk("midrst_status", ReadData, 32'h2);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
        step(0, A_ST, 0, 1, rd, ov, od);
        chk("postrst_status", rd, 32'h2);
        step(0, 32'h10, 0, 1, rd, ov, od);
        chk("postrst_ram", rd, 32'hDEAD_BEEF);

        // Randomized traffic against the model
        repeat (1500) begin
            we = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 1) == 1)
                adr = {1'b0, 31'($urandom)};
            else
                adr = {1'b1, 27'($urandom), 2'($urandom_range(0, 3)), 2'($urandom)};
            step(we, adr, $urandom, 1'($urandom_range(0, 1)), rd, ov, od);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
